// File: rtl/regfile_wb_arbiter_if.sv
// ----------------------------------------------------------------------------
// regfile_wb_arbiter_if
// Bundles the two producer handshakes (ALU and memory-load), the register-file
// write port and the busy scoreboard of regfile_wb_arbiter.
//
// Signals
//   alu_valid/alu_ready/alu_dr/alu_data  ALU write request channel
//   mem_valid/mem_ready/mem_dr/mem_data  memory-load write request channel
//   LDREG/dr/bus                         registered register-file write port
//   busy                                 one bit per register with a pending write
//
// Modports
//   master : producer / register-file side
//   slave  : the arbiter itself
// ----------------------------------------------------------------------------
interface regfile_wb_arbiter_if #(
    parameter int DATA_W = 16,
    parameter int ADDR_W = 3
);
    logic                       alu_valid;
    logic                       alu_ready;
    logic [ADDR_W-1:0]          alu_dr;
    logic [DATA_W-1:0]          alu_data;

    logic                       mem_valid;
    logic                       mem_ready;
    logic [ADDR_W-1:0]          mem_dr;
    logic [DATA_W-1:0]          mem_data;

    logic                       LDREG;
    logic [ADDR_W-1:0]          dr;
    logic [DATA_W-1:0]          bus;
    logic [(1<<ADDR_W)-1:0]     busy;

    modport master (
        output alu_valid, alu_dr, alu_data,
        output mem_valid, mem_dr, mem_data,
        input  alu_ready, mem_ready,
        input  LDREG, dr, bus, busy
    );

    modport slave (
        input  alu_valid, alu_dr, alu_data,
        input  mem_valid, mem_dr, mem_data,
        output alu_ready, mem_ready,
        output LDREG, dr, bus, busy
    );
endinterface

// File: rtl/regfile_wb_arbiter.sv
// ----------------------------------------------------------------------------
// regfile_wb_arbiter
// Write-back arbiter and scoreboard for the LC-3 register file's single write
// port. ALU and memory-load writes are queued in small per-source FIFOs and
// drained one per cycle with round-robin priority through registered
// LDREG/dr/bus outputs. A per-register pending counter drives the busy vector
// so the control FSM can stall on read-after-write hazards.
//
// Ports
//   Clk    in  rising-edge clock
//   Reset  in  asynchronous reset, active low
//   wb     slave modport of regfile_wb_arbiter_if (producer channels,
//          register-file write port, busy vector)
// ----------------------------------------------------------------------------
module regfile_wb_arbiter #(
    parameter int DATA_W     = 16,
    parameter int ADDR_W     = 3,
    parameter int FIFO_DEPTH = 2
) (
    input  logic                  Clk,
    input  logic                  Reset,
    regfile_wb_arbiter_if.slave   wb
);

    localparam int NREG   = 1 << ADDR_W;
    localparam int CNT_W  = $clog2(FIFO_DEPTH + 1);
    localparam int PTR_W  = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
    localparam int PEND_W = $clog2(2*FIFO_DEPTH + 2);
    localparam logic [CNT_W-1:0] DEPTH_C  = CNT_W'(FIFO_DEPTH);
    localparam logic [PTR_W-1:0] LAST_PTR = PTR_W'(FIFO_DEPTH - 1);

    typedef enum logic {SRC_ALU = 1'b0, SRC_MEM = 1'b1} src_e;

    // Index 0 is the ALU source, index 1 the memory-load source.
    logic [ADDR_W-1:0] fifo_dr   [2][FIFO_DEPTH];
    logic [DATA_W-1:0] fifo_data [2][FIFO_DEPTH];
    logic [PTR_W-1:0]  rd_ptr    [2];
    logic [PTR_W-1:0]  wr_ptr    [2];
    logic [CNT_W-1:0]  count     [2];
    logic [ADDR_W-1:0] in_dr     [2];
    logic [DATA_W-1:0] in_data   [2];
    logic [1:0]        ready;
    logic [1:0]        push;
    logic [1:0]        pop;
    logic [1:0]        not_empty;
    logic              pop_any;
    src_e              grant;
    src_e              last_grant;
    logic [ADDR_W-1:0] head_dr;
    logic [DATA_W-1:0] head_data;

    logic [PEND_W-1:0] pending   [NREG];
    logic [PEND_W-1:0] pend_next [NREG];

    function automatic logic [PTR_W-1:0] next_ptr(input logic [PTR_W-1:0] p);
        return (p == LAST_PTR) ? '0 : p + 1'b1;
    endfunction

    // Ready depends only on occupancy, never on valid, so producers see no
    // combinational loop through the arbiter.
    always_comb begin
        in_dr[0]   = wb.alu_dr;
        in_dr[1]   = wb.mem_dr;
        in_data[0] = wb.alu_data;
        in_data[1] = wb.mem_data;
        for (int s = 0; s < 2; s++) begin
            ready[s]     = (count[s] < DEPTH_C);
            not_empty[s] = (count[s] != '0);
        end
        push[0] = wb.alu_valid && ready[0];
        push[1] = wb.mem_valid && ready[1];
    end

    assign wb.alu_ready = ready[0];
    assign wb.mem_ready = ready[1];

    // Round-robin: on a tie the source that was not granted last wins. Only
    // heads present before this edge are considered, so there is no bypass.
    always_comb begin
        pop_any = |not_empty;
        grant   = SRC_ALU;
        if (&not_empty)
            grant = (last_grant == SRC_MEM) ? SRC_ALU : SRC_MEM;
        else if (not_empty[1])
            grant = SRC_MEM;
        pop[0]    = pop_any && (grant == SRC_ALU);
        pop[1]    = pop_any && (grant == SRC_MEM);
        head_dr   = (grant == SRC_MEM) ? fifo_dr[1][rd_ptr[1]]   : fifo_dr[0][rd_ptr[0]];
        head_data = (grant == SRC_MEM) ? fifo_data[1][rd_ptr[1]] : fifo_data[0][rd_ptr[0]];
    end

    // FIFO storage carries no reset; validity is tracked by the counts.
    always_ff @(posedge Clk) begin
        for (int s = 0; s < 2; s++) begin
            if (push[s]) begin
                fifo_dr[s][wr_ptr[s]]   <= in_dr[s];
                fifo_data[s][wr_ptr[s]] <= in_data[s];
            end
        end
    end

    // Pointers and occupancy; a simultaneous push and pop leaves the count alone.
    always_ff @(posedge Clk or negedge Reset) begin
        if (!Reset) begin
            for (int s = 0; s < 2; s++) begin
                rd_ptr[s] <= '0;
                wr_ptr[s] <= '0;
                count[s]  <= '0;
            end
        end else begin
            for (int s = 0; s < 2; s++) begin
                if (push[s]) wr_ptr[s] <= next_ptr(wr_ptr[s]);
                if (pop[s])  rd_ptr[s] <= next_ptr(rd_ptr[s]);
                case ({push[s], pop[s]})
                    2'b10:   count[s] <= count[s] + 1'b1;
                    2'b01:   count[s] <= count[s] - 1'b1;
                    default: ;
                endcase
            end
        end
    end

    // Registered write port plus the round-robin history. Reset leaves
    // last_grant at MEM so the ALU wins the first tie.
    always_ff @(posedge Clk or negedge Reset) begin
        if (!Reset) begin
            wb.LDREG   <= 1'b0;
            wb.dr      <= '0;
            wb.bus     <= '0;
            last_grant <= SRC_MEM;
        end else begin
            wb.LDREG <= pop_any;
            if (pop_any) begin
                wb.dr      <= head_dr;
                wb.bus     <= head_data;
                last_grant <= grant;
            end
        end
    end

    // Pending count per register: up by each accepted request naming it, down
    // by the commit currently presented on the write port.
    always_comb begin
        for (int i = 0; i < NREG; i++) begin
            pend_next[i] = pending[i]
                         + PEND_W'(push[0] && (in_dr[0] == ADDR_W'(i)))
                         + PEND_W'(push[1] && (in_dr[1] == ADDR_W'(i)))
                         - PEND_W'(wb.LDREG && (wb.dr == ADDR_W'(i)));
            wb.busy[i]   = (pending[i] != '0);
        end
    end

    always_ff @(posedge Clk or negedge Reset) begin
        if (!Reset) begin
            for (int i = 0; i < NREG; i++) pending[i] <= '0;
        end else begin
            for (int i = 0; i < NREG; i++) pending[i] <= pend_next[i];
        end
    end

endmodule

// File: tb/tb_regfile_wb_arbiter.sv
// ----------------------------------------------------------------------------
// tb_regfile_wb_arbiter
// Self-checking bench for regfile_wb_arbiter. A queue-based reference model
// of the two producer FIFOs, the round-robin grant and the per-register
// pending counts predicts every output; directed steps cover reset, single
// write, tie alternation, backpressure, same-register collision and an
// asynchronous reset mid-stream.
// ----------------------------------------------------------------------------
module tb_regfile_wb_arbiter;

    localparam int DATA_W = 16;
    localparam int ADDR_W = 3;
    localparam int DEPTH  = 2;
    localparam int NREG   = 8;

    logic Clk   = 1'b0;
    logic Reset = 1'b1;

    regfile_wb_arbiter_if #(.DATA_W(DATA_W), .ADDR_W(ADDR_W)) wbIf ();

    regfile_wb_arbiter #(
        .DATA_W     (DATA_W),
        .ADDR_W     (ADDR_W),
        .FIFO_DEPTH (DEPTH)
    ) dut (
        .Clk   (Clk),
        .Reset (Reset),
        .wb    (wbIf)
    );

    always #5 Clk = ~Clk;

    int testsRun    = 0;
    int testsFailed = 0;

    // Reference model state
    typedef struct {
        logic [ADDR_W-1:0] dr;
        logic [DATA_W-1:0] data;
    } wr_t;

    wr_t               aluQ[$];
    wr_t               memQ[$];
    int                pend [NREG];
    bit                mLd;
    logic [ADDR_W-1:0] mDr;
    logic [DATA_W-1:0] mBus;
    bit                lastWasMem;
    bit                accA;
    bit                accM;

    task automatic checkOutput(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        testsRun++;
        assert (obs === exp) else begin
            testsFailed++;
            $error("[TB] FAIL %s: observed %0h, expected %0h", tag, obs, exp);
        end
    endtask

    function automatic logic [NREG-1:0] expBusy();
        logic [NREG-1:0] b;
        for (int i = 0; i < NREG; i++) b[i] = (pend[i] != 0);
        return b;
    endfunction

    task automatic modelReset();
        aluQ.delete();
        memQ.delete();
        for (int i = 0; i < NREG; i++) pend[i] = 0;
        mLd        = 1'b0;
        mDr        = '0;
        mBus       = '0;
        lastWasMem = 1'b1;
        accA       = 1'b0;
        accM       = 1'b0;
    endtask

    // One rising edge of the model: retire the presented write, grant a head
    // present before the edge, then enqueue accepted requests.
    task automatic modelEdge();
        bit  aOk, mOk, pickMem;
        wr_t w;
        aOk = wbIf.alu_valid && (aluQ.size() < DEPTH);
        mOk = wbIf.mem_valid && (memQ.size() < DEPTH);
        if (mLd) pend[mDr]--;
        if (aluQ.size() > 0 || memQ.size() > 0) begin
            if (aluQ.size() > 0 && memQ.size() > 0) pickMem = !lastWasMem;
            else                                    pickMem = (memQ.size() > 0);
            w          = pickMem ? memQ.pop_front() : aluQ.pop_front();
            mLd        = 1'b1;
            mDr        = w.dr;
            mBus       = w.data;
            lastWasMem = pickMem;
        end else begin
            mLd = 1'b0;
        end
        if (aOk) begin
            aluQ.push_back('{dr: wbIf.alu_dr, data: wbIf.alu_data});
            pend[wbIf.alu_dr]++;
        end
        if (mOk) begin
            memQ.push_back('{dr: wbIf.mem_dr, data: wbIf.mem_data});
            pend[wbIf.mem_dr]++;
        end
        accA = aOk;
        accM = mOk;
    endtask

    task automatic applyStimulus(input bit av, input logic [ADDR_W-1:0] adr, input logic [DATA_W-1:0] ad,
                                 input bit mv, input logic [ADDR_W-1:0] mdr, input logic [DATA_W-1:0] md);
        wbIf.alu_valid = av;
        wbIf.alu_dr    = adr;
        wbIf.alu_data  = ad;
        wbIf.mem_valid = mv;
        wbIf.mem_dr    = mdr;
        wbIf.mem_data  = md;
    endtask

    // Checks ready before the edge, advances one clock, checks the write port
    // and busy vector 1 time unit after the edge.
    task automatic stepClock();
        checkOutput("alu_ready", wbIf.alu_ready, (aluQ.size() < DEPTH));
        checkOutput("mem_ready", wbIf.mem_ready, (memQ.size() < DEPTH));
        @(posedge Clk);
        if (Reset) modelEdge();
        #1;
        checkOutput("LDREG", wbIf.LDREG, mLd);
        checkOutput("dr",    wbIf.dr,    mDr);
        checkOutput("bus",   wbIf.bus,   mBus);
        checkOutput("busy",  wbIf.busy,  expBusy());
    endtask

    bit                aV, mV;
    logic [ADDR_W-1:0] aD, mD;
    logic [DATA_W-1:0] aX, mX;
    bit                sawAluFull, sawMemFull;

    initial begin
        modelReset();
        applyStimulus(1'b0, '0, '0, 1'b0, '0, '0);

        // Cold reset with both requests asserted: nothing may be accepted.
        #1 Reset = 1'b0;
        applyStimulus(1'b1, 3'd4, 16'hAAAA, 1'b1, 3'd6, 16'hBBBB);
        #1;
        checkOutput("cold_ldreg",     wbIf.LDREG,     1'b0);
        checkOutput("cold_busy",      wbIf.busy,      8'h00);
        checkOutput("cold_alu_ready", wbIf.alu_ready, 1'b1);
        checkOutput("cold_mem_ready", wbIf.mem_ready, 1'b1);
        stepClock();
        stepClock();
        checkOutput("cold_busy_held", wbIf.busy, 8'h00);
        #3 Reset = 1'b1;
        stepClock();
        applyStimulus(1'b0, '0, '0, 1'b0, '0, '0);
        stepClock();
        checkOutput("cold_first_grant_dr",  wbIf.dr,  3'd4);
        checkOutput("cold_first_grant_bus", wbIf.bus, 16'hAAAA);
        stepClock();
        checkOutput("cold_second_grant_dr", wbIf.dr, 3'd6);
        stepClock();
        stepClock();

        // Single ALU write.
        applyStimulus(1'b1, 3'd3, 16'h1234, 1'b0, '0, '0);
        stepClock();
        checkOutput("single_busy_e0", wbIf.busy, 8'h08);
        applyStimulus(1'b0, '0, '0, 1'b0, '0, '0);
        stepClock();
        checkOutput("single_ldreg_e1", wbIf.LDREG, 1'b1);
        checkOutput("single_dr_e1",    wbIf.dr,    3'd3);
        checkOutput("single_bus_e1",   wbIf.bus,   16'h1234);
        stepClock();
        checkOutput("single_ldreg_e2", wbIf.LDREG, 1'b0);
        checkOutput("single_busy_e2",  wbIf.busy,  8'h00);

        // Tie round-robin: both sources valid every cycle, producers hold
        // unaccepted requests.
        sawAluFull = 1'b0;
        sawMemFull = 1'b0;
        aX = 16'($urandom);
        mX = 16'($urandom);
        for (int i = 0; i < 20; i++) begin
            applyStimulus(1'b1, 3'd1, aX, 1'b1, 3'd2, mX);
            stepClock();
            if (accA) aX = 16'($urandom);
            if (accM) mX = 16'($urandom);
            if (!wbIf.alu_ready) sawAluFull = 1'b1;
            if (!wbIf.mem_ready) sawMemFull = 1'b1;
            if (i >= 2) checkOutput("tie_ldreg_stuck", wbIf.LDREG, 1'b1);
        end
        checkOutput("tie_alu_backpressure", sawAluFull, 1'b1);
        checkOutput("tie_mem_backpressure", sawMemFull, 1'b1);
        applyStimulus(1'b0, '0, '0, 1'b0, '0, '0);
        for (int i = 0; i < 6; i++) stepClock();

        // Randomised traffic with backpressure; unaccepted requests are held.
        aV = 1'b0;
        mV = 1'b0;
        sawMemFull = 1'b0;
        for (int i = 0; i < 200; i++) begin
            if (!aV || accA) begin
                aV = ($urandom_range(0, 3) != 0);
                aD = 3'($urandom);
                aX = 16'($urandom);
            end
            if (!mV || accM) begin
                mV = ($urandom_range(0, 9) != 0);
                mD = 3'($urandom);
                mX = 16'($urandom);
            end
            applyStimulus(aV, aD, aX, mV, mD, mX);
            accA = 1'b0;
            accM = 1'b0;
            stepClock();
            if (!wbIf.mem_ready) sawMemFull = 1'b1;
        end
        checkOutput("rand_mem_backpressure", sawMemFull, 1'b1);
        applyStimulus(1'b0, '0, '0, 1'b0, '0, '0);
        for (int i = 0; i < 8; i++) stepClock();
        checkOutput("rand_drained_busy", wbIf.busy, 8'h00);

        // Same-register collision right after reset: ALU value commits first.
        Reset = 1'b0;
        modelReset();
        #2 Reset = 1'b1;
        aX = 16'($urandom);
        mX = 16'($urandom);
        applyStimulus(1'b1, 3'd5, aX, 1'b1, 3'd5, mX);
        stepClock();
        checkOutput("coll_busy_e0", wbIf.busy, 8'h20);
        applyStimulus(1'b0, '0, '0, 1'b0, '0, '0);
        stepClock();
        checkOutput("coll_first_dr",  wbIf.dr,   3'd5);
        checkOutput("coll_first_bus", wbIf.bus,  aX);
        checkOutput("coll_busy_e1",   wbIf.busy, 8'h20);
        stepClock();
        checkOutput("coll_second_ldreg", wbIf.LDREG, 1'b1);
        checkOutput("coll_second_bus",   wbIf.bus,   mX);
        checkOutput("coll_busy_e2",      wbIf.busy,  8'h20);
        stepClock();
        checkOutput("coll_busy_clear", wbIf.busy,  8'h00);
        checkOutput("coll_ldreg_idle", wbIf.LDREG, 1'b0);

        // Asynchronous reset mid-stream.
        for (int i = 0; i < 4; i++) begin
            applyStimulus(1'b1, 3'($urandom), 16'($urandom), 1'b1, 3'($urandom), 16'($urandom));
            stepClock();
        end
        checkOutput("midrst_pre_ldreg", wbIf.LDREG, 1'b1);
        #2 Reset = 1'b0;
        #1;
        checkOutput("midrst_ldreg",     wbIf.LDREG,     1'b0);
        checkOutput("midrst_busy",      wbIf.busy,      8'h00);
        checkOutput("midrst_alu_ready", wbIf.alu_ready, 1'b1);
        checkOutput("midrst_mem_ready", wbIf.mem_ready, 1'b1);
        modelReset();
        applyStimulus(1'b0, '0, '0, 1'b0, '0, '0);
        stepClock();
        #3 Reset = 1'b1;
        for (int i = 0; i < 4; i++) stepClock();
        checkOutput("midrst_no_leftover", wbIf.LDREG, 1'b0);

        $display("[TB] %0d tests run, %0d failed", testsRun, testsFailed);
        $finish;
    end

endmodule
